fill_seal_line: RTL and testbench

- Parametrised successor of the single-line fill/seal controller.
- Drives N_CH independent filling stations that share one sealing head. Sealer access is arbitrated round-robin.
- Fill and seal durations are parameters, counted in tick periods, so the block runs from the fast system clock with a 1 Hz (or any) tick enable.
- Exposes per-channel status LEDs, per-FSM state indicators and a saturating count of sealed products.

---
 rtl/fill_seal_line_if.sv | 28 ++
 rtl/fill_seal_line.sv | 152 +++++++++++++++
 tb/tb_fill_seal_line.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fill_seal_line_if.sv
// rtl/fill_seal_line_if.sv - handshake and status bundle for the fill/seal line
interface fill_seal_line_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 8
);
    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                tick;
    logic [N_CH-1:0]     startfill;
    logic [N_CH-1:0]     productook;
    logic [N_CH-1:0]     llenando;
    logic [N_CH-1:0]     sellando;
    logic [N_CH-1:0]     sealed;
    logic [3*N_CH-1:0]   state_filler;
    logic [2:0]          state_sealer;
    logic [GW-1:0]       grant_ch;
    logic [CNT_W-1:0]    seal_count;

    modport master (
        output tick, startfill, productook,
        input  llenando, sellando, sealed, state_filler, state_sealer, grant_ch, seal_count
    );

    modport slave (
        input  tick, startfill, productook,
        output llenando, sellando, sealed, state_filler, state_sealer, grant_ch, seal_count
    );
endinterface

// File: rtl/fill_seal_line.sv
// rtl/fill_seal_line.sv - N filling stations sharing one round-robin arbitrated sealer
module fill_seal_line #(
    parameter int N_CH       = 2,
    parameter int FILL_TICKS = 3,
    parameter int SEAL_TICKS = 2,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    fill_seal_line_if.slave bus
);
    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FW = $clog2(FILL_TICKS + 1);
    localparam int SW = $clog2(SEAL_TICKS + 1);

    typedef enum logic [2:0] {F_IDLE = 3'b001, F_FILLING = 3'b010, F_FULL = 3'b100} fstate_t;
    typedef enum logic [2:0] {S_IDLE = 3'b001, S_SEALING = 3'b010, S_DONE = 3'b100} sstate_t;

    fstate_t          fstate_q [N_CH];
    fstate_t          fstate_d [N_CH];
    logic [FW-1:0]    fcnt_q   [N_CH];
    logic [FW-1:0]    fcnt_d   [N_CH];
    sstate_t          sstate_q, sstate_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_CH-1:0]  cand;
    logic [N_CH-1:0]  release_ch;
    logic             abort;
    logic             hi_found, lo_found;
    logic [GW-1:0]    hi_win, lo_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) begin
                fstate_q[k] <= F_IDLE;
                fcnt_q[k]   <= '0;
            end
            sstate_q <= S_IDLE;
            scnt_q   <= '0;
            grant_q  <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
        end else begin
            fstate_q <= fstate_d;
            fcnt_q   <= fcnt_d;
            sstate_q <= sstate_d;
            scnt_q   <= scnt_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Round-robin pick: lowest candidate at or above rr_q, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand[k] = (fstate_q[k] == F_FULL) && bus.productook[k];
            if (cand[k]) begin
                lo_found = 1'b1;
                lo_win   = GW'(k);
                if (GW'(k) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_win   = GW'(k);
                end
            end
        end
    end

    always_comb begin
        sstate_d   = sstate_q;
        scnt_d     = scnt_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        release_ch = '0;
        abort      = (sstate_q == S_SEALING) && !bus.productook[grant_q];

        // Losing the product mid-seal bypasses the tick gate and beats completion.
        if (abort) begin
            sstate_d = S_IDLE;
        end else if (bus.tick) begin
            case (sstate_q)
                S_IDLE: begin
                    if (lo_found) begin
                        grant_d  = hi_found ? hi_win : lo_win;
                        scnt_d   = SW'(SEAL_TICKS - 1);
                        sstate_d = S_SEALING;
                    end
                end
                S_SEALING: begin
                    if (scnt_q == '0) sstate_d = S_DONE;
                    else              scnt_d   = scnt_q - SW'(1);
                end
                S_DONE: begin
                    sstate_d            = S_IDLE;
                    release_ch[grant_q] = 1'b1;
                    rr_d                = (grant_q == GW'(N_CH - 1)) ? '0 : grant_q + GW'(1);
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                end
                default: sstate_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fstate_d = fstate_q;
        fcnt_d   = fcnt_q;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.tick) begin
                case (fstate_q[k])
                    F_IDLE: begin
                        if (bus.startfill[k]) begin
                            fstate_d[k] = F_FILLING;
                            fcnt_d[k]   = FW'(FILL_TICKS - 1);
                        end
                    end
                    F_FILLING: begin
                        if (fcnt_q[k] == '0) fstate_d[k] = F_FULL;
                        else                 fcnt_d[k]   = fcnt_q[k] - FW'(1);
                    end
                    F_FULL: begin
                        if (release_ch[k]) fstate_d[k] = F_IDLE;
                    end
                    default: fstate_d[k] = F_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.llenando     = '0;
        bus.sellando     = '0;
        bus.sealed       = '0;
        bus.state_filler = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.llenando[k]           = (fstate_q[k] == F_FILLING);
            bus.sellando[k]           = (sstate_q == S_SEALING) && (grant_q == GW'(k)) && bus.productook[k];
            bus.sealed[k]             = (sstate_q == S_DONE) && (grant_q == GW'(k));
            bus.state_filler[3*k +: 3] = fstate_q[k];
        end
        bus.state_sealer = sstate_q;
        bus.grant_ch     = grant_q;
        bus.seal_count   = cnt_q;
    end
endmodule

// File: tb/tb_fill_seal_line.sv
// tb/tb_fill_seal_line.sv - self-checking bench for fill_seal_line
module tb_fill_seal_line;
    localparam int NCH  = 2;
    localparam int FILL = 3;
    localparam int SEAL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       tk = 1'b0;
    logic [1:0] sf = 2'b00;
    logic [1:0] pt = 2'b00;

    int total = 0;
    int bad   = 0;

    fill_seal_line_if #(.N_CH(NCH), .CNT_W(8)) bus   ();
    fill_seal_line_if #(.N_CH(NCH), .CNT_W(2)) bus_s ();

    assign bus.tick         = tk;
    assign bus.startfill    = sf;
    assign bus.productook   = pt;
    assign bus_s.tick       = tk;
    assign bus_s.startfill  = sf;
    assign bus_s.productook = pt;

    fill_seal_line #(.N_CH(NCH), .FILL_TICKS(FILL), .SEAL_TICKS(SEAL), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    fill_seal_line #(.N_CH(NCH), .FILL_TICKS(FILL), .SEAL_TICKS(SEAL), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave)
    );

    always #5 clk = ~clk;

    // Reference: 0/1/2 phases with "ticks remaining" counters and an unbounded seal total.
    int m_fill [NCH];
    int m_fleft[NCH];
    int m_seal, m_sleft, m_grant, m_rr, m_count;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_fill[k]  = 0;
            m_fleft[k] = 0;
        end
        m_seal = 0; m_sleft = 0; m_grant = 0; m_rr = 0; m_count = 0;
    endtask

    task automatic model_step();
        int rel;
        bit got;
        rel = -1;
        got = 1'b0;
        if (m_seal == 1 && !pt[m_grant]) begin
            m_seal = 0;
        end else if (tk) begin
            if (m_seal == 0) begin
                for (int i = 0; i < NCH; i++) begin
                    int c;
                    c = (m_rr + i) % NCH;
                    if (!got && m_fill[c] == 2 && pt[c]) begin
                        got = 1'b1;
                        m_grant = c;
                    end
                end
                if (got) begin
                    m_seal  = 1;
                    m_sleft = SEAL;
                end
            end else if (m_seal == 1) begin
                m_sleft--;
                if (m_sleft == 0) m_seal = 2;
            end else begin
                m_seal = 0;
                rel = m_grant;
                m_rr = (m_grant + 1) % NCH;
                m_count++;
            end
        end
        if (tk) begin
            for (int k = 0; k < NCH; k++) begin
                if (m_fill[k] == 0) begin
                    if (sf[k]) begin
                        m_fill[k]  = 1;
                        m_fleft[k] = FILL;
                    end
                end else if (m_fill[k] == 1) begin
                    m_fleft[k]--;
                    if (m_fleft[k] == 0) m_fill[k] = 2;
                end else if (rel == k) begin
                    m_fill[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [1:0] e_llen, e_sell, e_sld;
        logic [5:0] e_sf;
        for (int k = 0; k < NCH; k++) begin
            e_llen[k]      = (m_fill[k] == 1);
            e_sell[k]      = (m_seal == 1) && (m_grant == k) && pt[k];
            e_sld[k]       = (m_seal == 2) && (m_grant == k);
            e_sf[3*k +: 3] = 3'(1 << m_fill[k]);
        end
        chk("llenando",     32'(bus.llenando),     32'(e_llen));
        chk("sellando",     32'(bus.sellando),     32'(e_sell));
        chk("sealed",       32'(bus.sealed),       32'(e_sld));
        chk("state_filler", 32'(bus.state_filler), 32'(e_sf));
        chk("state_sealer", 32'(bus.state_sealer), 32'(1 << m_seal));
        chk("grant_ch",     32'(bus.grant_ch),     32'(m_grant));
        chk("seal_count",   32'(bus.seal_count),   32'((m_count > 255) ? 255 : m_count));
        chk("seal_count_sat", 32'(bus_s.seal_count), 32'((m_count > 3) ? 3 : m_count));
    endtask

    task automatic apply(input logic t, input logic [1:0] s, input logic [1:0] p);
        tk = t; sf = s; pt = p;
        #1;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(input logic t, input logic [1:0] s, input logic [1:0] p);
        apply(t, s, p);
        check_all();
        finish_cycle();
    endtask

    // Called at a falling edge; reset lands mid-cycle so asynchronous clearing is visible.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_state_filler", 32'(bus.state_filler), 32'h09);
        chk("rst_state_sealer", 32'(bus.state_sealer), 32'h1);
        chk("rst_llenando",     32'(bus.llenando),     32'h0);
        chk("rst_sellando",     32'(bus.sellando),     32'h0);
        chk("rst_sealed",       32'(bus.sealed),       32'h0);
        chk("rst_grant",        32'(bus.grant_ch),     32'h0);
        chk("rst_count",        32'(bus.seal_count),   32'h0);
        chk("rst_count_sat",    32'(bus_s.seal_count), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic       t;
        logic [1:0] s, p;
        logic [1:0] llen, sell, sld;
        logic [5:0] sfs;
        logic [2:0] sss;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int order[$];
        int n_llen, n_sell;
        logic t;

        tbl[0] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 6'b001001, 3'b001, 8'd0};
        tbl[1] = '{1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 6'b001010, 3'b001, 8'd0};
        tbl[2] = '{1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 6'b001010, 3'b001, 8'd0};
        tbl[3] = '{1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 6'b001010, 3'b001, 8'd0};
        tbl[4] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b001100, 3'b001, 8'd0};
        tbl[5] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 6'b001100, 3'b010, 8'd0};
        tbl[6] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 6'b001100, 3'b010, 8'd0};
        tbl[7] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 6'b001100, 3'b100, 8'd0};
        tbl[8] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b001001, 3'b001, 8'd1};

        model_reset();
        tk = 1'b1;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 2'b11);
        chk("idle_no_start", 32'(bus.state_filler), 32'h09);

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].t, tbl[i].s, tbl[i].p);
            chk("tbl_llenando", 32'(bus.llenando),     32'(tbl[i].llen));
            chk("tbl_sellando", 32'(bus.sellando),     32'(tbl[i].sell));
            chk("tbl_sealed",   32'(bus.sealed),       32'(tbl[i].sld));
            chk("tbl_filler",   32'(bus.state_filler), 32'(tbl[i].sfs));
            chk("tbl_sealer",   32'(bus.state_sealer), 32'(tbl[i].sss));
            chk("tbl_count",    32'(bus.seal_count),   32'(tbl[i].cnt));
            check_all();
            finish_cycle();
        end

        // Contention: both stations full together, round-robin order 0,1 then 0,1 again.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 25; i++) begin
                apply(1'b1, (i == 0) ? 2'b11 : 2'b00, 2'b11);
                check_all();
                if (bus.sealed != 2'b00) order.push_back(int'(bus.grant_ch));
                finish_cycle();
            end
        end
        chk("seal_events", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
        chk("contention_count", 32'(bus.seal_count), 32'd4);

        // Abort in the first sealing cycle.
        do_reset();
        step(1'b1, 2'b01, 2'b01);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 2'b01);
        apply(1'b1, 2'b00, 2'b00);
        chk("abort_pre_sealer", 32'(bus.state_sealer), 32'h2);
        chk("abort_sell_drop",  32'(bus.sellando),     32'h0);
        check_all();
        finish_cycle();
        apply(1'b1, 2'b00, 2'b01);
        chk("abort_sealer_idle", 32'(bus.state_sealer), 32'h1);
        chk("abort_still_full",  32'(bus.state_filler[2:0]), 32'h4);
        chk("abort_count",       32'(bus.seal_count), 32'h0);
        check_all();
        finish_cycle();
        n_sell = 0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 2'b00, 2'b01);
            check_all();
            if (bus.sellando[0]) n_sell++;
            finish_cycle();
        end
        apply(1'b1, 2'b00, 2'b01);
        chk("reseal_cycles", 32'(n_sell), 32'd2);
        chk("reseal_count",  32'(bus.seal_count), 32'd1);
        check_all();
        finish_cycle();

        // Tick every 4th cycle; startfill offered only on untick cycles first.
        do_reset();
        n_llen = 0;
        n_sell = 0;
        for (int i = 0; i < 60; i++) begin
            t = (i % 4 == 0);
            apply(t, (i >= 1 && i <= 4) ? 2'b01 : 2'b00, 2'b01);
            if (i == 4) chk("untick_start_ignored", 32'(bus.state_filler[2:0]), 32'h1);
            check_all();
            if (bus.llenando[0]) n_llen++;
            if (bus.sellando[0]) n_sell++;
            finish_cycle();
        end
        chk("gated_fill_len", 32'(n_llen), 32'd12);
        chk("gated_seal_len", 32'(n_sell), 32'd8);

        // Saturation of the narrow counter.
        do_reset();
        for (int i = 0; i < 100 && m_count < 6; i++) step(1'b1, 2'b01, 2'b01);
        chk("six_seals_reached", 32'(m_count >= 6), 32'd1);
        chk("sat_count", 32'(bus_s.seal_count), 32'd3);

        // Reset mid-fill.
        do_reset();
        step(1'b1, 2'b01, 2'b01);
        step(1'b1, 2'b00, 2'b01);
        chk("filling_before_rst", 32'(bus.llenando[0]), 32'd1);
        do_reset();
        step(1'b1, 2'b01, 2'b01);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 2'b01);
        apply(1'b1, 2'b00, 2'b01);
        chk("restart_count", 32'(bus.seal_count), 32'd1);
        check_all();
        finish_cycle();

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 2'($urandom),
                 {($urandom % 8) != 0, ($urandom % 8) != 0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
